// File: rtl/nn_pkg.sv
// Shared types and constants for the activation/MAC sequencer.
package nn_pkg;

    // Sequencer states, in the order a neuron group walks through them.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_MAC,
        ST_DRAIN,
        ST_ACT,
        ST_WRITE,
        ST_NEXT,
        ST_DONE
    } state_t;

    // Activation function select; the reserved code behaves as passthrough.
    typedef enum logic [1:0] {
        MODE_SIGMOID = 2'b00,
        MODE_RELU    = 2'b01,
        MODE_PASS    = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_t;

    // Bit positions inside r_sh_en.
    localparam int RSH_ACT_FETCH = 0;
    localparam int RSH_ACT       = 1;
    localparam int RSH_WRITE     = 2;

    // Width of a lane index; at least one bit so a single-lane build still has a port.
    function automatic int lane_width(input int n_lanes);
        return (n_lanes > 1) ? $clog2(n_lanes) : 1;
    endfunction

endpackage

// File: rtl/sm_lane_mask.sv
// Active-lane mask for the current neuron group and LUT index saturation
// for the selected lane. Purely combinational.
module sm_lane_mask #(
    parameter int ADDR_WIDTH = 16,
    parameter int N_LANES    = 2,
    parameter int LUT_DEPTH  = 256,
    parameter int LANE_W     = 1
) (
    input  logic [ADDR_WIDTH-1:0]         out_cnt,
    input  logic [ADDR_WIDTH-1:0]         n_out,
    input  logic [N_LANES*ADDR_WIDTH-1:0] lut_idx,
    input  logic [LANE_W-1:0]             lane_sel,
    output logic [N_LANES-1:0]            mask,
    output logic [ADDR_WIDTH-1:0]         sat_pos
);

    localparam logic [ADDR_WIDTH-1:0] LUT_MAX = ADDR_WIDTH'(LUT_DEPTH - 1);

    logic [ADDR_WIDTH-1:0] idx;

    // Lane k is live while out_cnt+k is still below n_out; one extra bit avoids wrap.
    always_comb begin
        mask = '0;
        for (int k = 0; k < N_LANES; k++) begin
            mask[k] = ({1'b0, out_cnt} + (ADDR_WIDTH + 1)'(k)) < {1'b0, n_out};
        end
    end

    // Pick the selected lane's index, clamp negatives to 0 and large values to the last entry.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no latch is inferred.
        idx     = '0;
        sat_pos = '0;
        for (int k = 0; k < N_LANES; k++) begin
            if (lane_sel == LANE_W'(k)) begin
                idx = lut_idx[k*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
        if (idx[ADDR_WIDTH-1]) begin
            sat_pos = '0;
        end else if (idx > LUT_MAX) begin
            sat_pos = LUT_MAX;
        end else begin
            sat_pos = idx;
        end
    end

endmodule

// File: rtl/sm_act_seq.sv
// Neural layer sequencer: clears and runs the MAC lanes over n_in inputs,
// drains the MAC pipeline, then applies the activation and writes one output
// per live lane, group after group until n_out neurons are done.
// All outputs are registered and describe the state just entered.
// MAC_LAT is expected to be at least 1.
module sm_act_seq
    import nn_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 16,
    parameter int                    N_LANES     = 2,
    parameter logic [ADDR_WIDTH-1:0] ADDR_BASE_A = '0,
    parameter logic [ADDR_WIDTH-1:0] ADDR_BASE_W = '0,
    parameter logic [ADDR_WIDTH-1:0] ADDR_BASE_O = '0,
    parameter int                    LUT_DEPTH   = 256,
    parameter int                    MAC_LAT     = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          reset,
    input  logic [1:0]                    mode,
    input  logic [ADDR_WIDTH-1:0]         n_in,
    input  logic [ADDR_WIDTH-1:0]         n_out,
    input  logic [N_LANES*ADDR_WIDTH-1:0] lut_idx,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [2:0]                    r_sh_en,
    output logic [N_LANES-1:0]            mac_en,
    output logic [N_LANES-1:0]            mac_clr,
    output logic [ADDR_WIDTH-1:0]         lut_pos,
    output logic                          lut_sel,
    output logic                          out_we,
    output logic [ADDR_WIDTH-1:0]         out_addr,
    output logic                          busy,
    output logic                          done
);

    localparam int LANE_W = lane_width(N_LANES);

    state_t                state;
    mode_t                 mode_r;
    logic [ADDR_WIDTH-1:0] n_in_r;
    logic [ADDR_WIDTH-1:0] n_out_r;
    logic [ADDR_WIDTH-1:0] in_cnt;
    logic [ADDR_WIDTH-1:0] out_cnt;
    logic [ADDR_WIDTH-1:0] w_ptr;
    logic [ADDR_WIDTH-1:0] o_ptr;
    logic [ADDR_WIDTH-1:0] drain_cnt;
    logic                  act_phase;   // 0: weight fetch sub-cycle, 1: activation fetch
    logic                  last_group;
    logic [LANE_W-1:0]     lane;
    logic [N_LANES-1:0]    lane_mask_r;

    logic                  at_rest;
    logic [ADDR_WIDTH-1:0] mask_cnt;
    logic [ADDR_WIDTH-1:0] mask_n;
    logic [LANE_W-1:0]     lane_sel;
    logic [N_LANES-1:0]    lane_mask;
    logic [ADDR_WIDTH-1:0] sat_pos;
    logic                  next_lane_active;

    // A new layer starts from group 0 with the incoming n_out, before anything is latched.
    assign at_rest  = (state == ST_IDLE) || (state == ST_DONE);
    assign mask_cnt = at_rest ? '0 : out_cnt;
    assign mask_n   = at_rest ? n_out : n_out_r;
    // Lane about to enter ACT: lane 0 from DRAIN, the following lane from WRITE.
    assign lane_sel = (state == ST_WRITE) ? lane + LANE_W'(1) : '0;

    sm_lane_mask #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .N_LANES    (N_LANES),
        .LUT_DEPTH  (LUT_DEPTH),
        .LANE_W     (LANE_W)
    ) u_lane_mask (
        .out_cnt  (mask_cnt),
        .n_out    (mask_n),
        .lut_idx  (lut_idx),
        .lane_sel (lane_sel),
        .mask     (lane_mask),
        .sat_pos  (sat_pos)
    );

    // True when the lane after the current one is live in this group.
    always_comb begin
        next_lane_active = 1'b0;
        for (int k = 1; k < N_LANES; k++) begin
            if (lane == LANE_W'(k - 1) && lane_mask_r[k]) begin
                next_lane_active = 1'b1;
            end
        end
    end

    // Sequencer: state, counters and all registered outputs for the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            mode_r      <= MODE_SIGMOID;
            n_in_r      <= '0;
            n_out_r     <= '0;
            in_cnt      <= '0;
            out_cnt     <= '0;
            w_ptr       <= '0;
            o_ptr       <= '0;
            drain_cnt   <= '0;
            act_phase   <= 1'b0;
            last_group  <= 1'b0;
            lane        <= '0;
            lane_mask_r <= '0;
            mem_addr    <= '0;
            r_sh_en     <= '0;
            mac_en      <= '0;
            mac_clr     <= '0;
            lut_pos     <= '0;
            lut_sel     <= 1'b0;
            out_we      <= 1'b0;
            out_addr    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            // NOTE: non-blocking defaults here are overridden by later assignments in the
            // same edge, so each state only names the outputs it actually drives.
            mem_addr <= '0;
            r_sh_en  <= '0;
            mac_en   <= '0;
            mac_clr  <= '0;
            lut_pos  <= '0;
            lut_sel  <= 1'b0;
            out_we   <= 1'b0;
            out_addr <= '0;
            done     <= 1'b0;
            busy     <= 1'b1;

            if (reset) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        if (start) begin
                            n_in_r  <= n_in;
                            n_out_r <= n_out;
                            mode_r  <= mode_t'(mode);
                            out_cnt <= '0;
                            w_ptr   <= ADDR_BASE_W;
                            o_ptr   <= ADDR_BASE_O;
                            if (n_in == '0 || n_out == '0) begin
                                state <= ST_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                state       <= ST_CLR;
                                mac_clr     <= lane_mask;
                                lane_mask_r <= lane_mask;
                                in_cnt      <= '0;
                                act_phase   <= 1'b0;
                            end
                        end else begin
                            busy <= 1'b0;
                            done <= (state == ST_DONE);
                        end
                    end

                    ST_CLR: begin
                        state    <= ST_MAC;
                        mac_en   <= lane_mask_r;
                        mem_addr <= w_ptr;
                        w_ptr    <= w_ptr + ADDR_WIDTH'(1);
                    end

                    ST_MAC: begin
                        mac_en <= lane_mask_r;
                        if (!act_phase) begin
                            act_phase              <= 1'b1;
                            mem_addr               <= ADDR_BASE_A + in_cnt;
                            r_sh_en[RSH_ACT_FETCH] <= 1'b1;
                        end else begin
                            act_phase <= 1'b0;
                            if (in_cnt + ADDR_WIDTH'(1) == n_in_r) begin
                                state     <= ST_DRAIN;
                                drain_cnt <= '0;
                                mac_en    <= '0;
                            end else begin
                                in_cnt   <= in_cnt + ADDR_WIDTH'(1);
                                mem_addr <= w_ptr;
                                w_ptr    <= w_ptr + ADDR_WIDTH'(1);
                            end
                        end
                    end

                    ST_DRAIN: begin
                        if (drain_cnt == ADDR_WIDTH'(MAC_LAT - 1)) begin
                            state            <= ST_ACT;
                            lane             <= lane_sel;
                            r_sh_en[RSH_ACT] <= 1'b1;
                            if (mode_r == MODE_SIGMOID) begin
                                lut_sel <= 1'b1;
                                lut_pos <= sat_pos;
                            end
                        end else begin
                            drain_cnt <= drain_cnt + ADDR_WIDTH'(1);
                        end
                    end

                    ST_ACT: begin
                        state              <= ST_WRITE;
                        out_we             <= 1'b1;
                        out_addr           <= o_ptr;
                        o_ptr              <= o_ptr + ADDR_WIDTH'(1);
                        r_sh_en[RSH_WRITE] <= 1'b1;
                    end

                    ST_WRITE: begin
                        if (next_lane_active) begin
                            state            <= ST_ACT;
                            lane             <= lane_sel;
                            r_sh_en[RSH_ACT] <= 1'b1;
                            if (mode_r == MODE_SIGMOID) begin
                                lut_sel <= 1'b1;
                                lut_pos <= sat_pos;
                            end
                        end else begin
                            state      <= ST_NEXT;
                            out_cnt    <= out_cnt + ADDR_WIDTH'(N_LANES);
                            last_group <= ({1'b0, out_cnt} + (ADDR_WIDTH + 1)'(N_LANES))
                                          >= {1'b0, n_out_r};
                        end
                    end

                    ST_NEXT: begin
                        if (last_group) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state       <= ST_CLR;
                            mac_clr     <= lane_mask;
                            lane_mask_r <= lane_mask;
                            in_cnt      <= '0;
                            act_phase   <= 1'b0;
                        end
                    end

                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
